// File: rtl/instr_decode_nibble_alu.sv
// instr_decode_nibble_alu
//   RV32I instruction field decoder (purely combinational) together with a
//   nibble-serial 32-bit ALU that processes 4 bits per clock over 8 cycles.
//
// Ports
//   clk           in   1   system clock, rising edge
//   rst_n         in   1   asynchronous active-low reset (ALU state only)
//   instr         in  32   instruction word to decode
//   alu_ctrl      in   3   ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5-7 NONE
//   word1, word2  in  32   ALU operands
//   perm_to_count in   1   level-sensitive start request
//   opcode/funct3/rs1/rs2/rd  out   raw instruction fields
//   imm           out 32   sign-extended I/S immediate, else 0
//   jump_addr     out 12   B-type offset bits [12:1] for BRANCH, else 0
//   alu_cmd       out  3   decoded ALU operation (alu_ctrl encoding)
//   result        out 32   ALU result, held until the next start
//   busy          out  1   operation in progress
//   nibble_idx    out  3   nibble to be processed on the next edge
module instr_decode_nibble_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [2:0]  alu_ctrl,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  input  logic        perm_to_count,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [11:0] jump_addr,
  output logic [2:0]  alu_cmd,
  output logic [31:0] result,
  output logic        busy,
  output logic [2:0]  nibble_idx
);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NONE = 3'd5;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // ---------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Immediate, branch offset and ALU command selection by opcode
  always_comb begin
    imm       = 32'h0000_0000;
    jump_addr = 12'h000;
    alu_cmd   = ALU_NONE;
    case (instr[6:0])
      OPC_OP_IMM: begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (instr[14:12])
          3'b000:  alu_cmd = ALU_ADD;
          3'b100:  alu_cmd = ALU_XOR;
          3'b110:  alu_cmd = ALU_OR;
          3'b111:  alu_cmd = ALU_AND;
          default: alu_cmd = ALU_NONE;
        endcase
      end
      OPC_LOAD: begin
        imm     = {{20{instr[31]}}, instr[31:20]};
        alu_cmd = ALU_ADD;
      end
      OPC_JALR: begin
        imm     = {{20{instr[31]}}, instr[31:20]};
        alu_cmd = ALU_NONE;
      end
      OPC_STORE: begin
        imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        alu_cmd = ALU_ADD;
      end
      OPC_BRANCH: begin
        jump_addr = {instr[31], instr[7], instr[30:25], instr[11:8]};
      end
      OPC_OP: begin
        case (instr[14:12])
          // instr[30] distinguishes SUB from ADD within funct3 000
          3'b000: begin
            if (instr[30]) begin
              alu_cmd = ALU_SUB;
            end else begin
              alu_cmd = ALU_ADD;
            end
          end
          3'b100:  alu_cmd = ALU_XOR;
          3'b110:  alu_cmd = ALU_OR;
          3'b111:  alu_cmd = ALU_AND;
          default: alu_cmd = ALU_NONE;
        endcase
      end
      default: begin
        imm       = 32'h0000_0000;
        jump_addr = 12'h000;
        alu_cmd   = ALU_NONE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Nibble-serial ALU
  // ---------------------------------------------------------------------
  state_t      state_r, state_nx;
  logic [2:0]  idx_r, idx_nx;
  logic [31:0] result_r, result_nx;
  logic        carry_r, carry_nx;
  logic [2:0]  op_r, op_nx;
  logic [31:0] w1_r, w1_nx;
  logic [31:0] w2_r, w2_nx;

  logic [3:0]  nib_a, nib_b, nib_b_eff, nib_res;
  logic [4:0]  nib_sum;
  logic        nib_carry;

  // Datapath for the current nibble; SUB adds the inverted operand with
  // the carry seeded to 1 at start, giving two's complement subtraction
  always_comb begin
    nib_a     = w1_r[{idx_r, 2'b00} +: 4];
    nib_b     = w2_r[{idx_r, 2'b00} +: 4];
    nib_b_eff = (op_r == ALU_SUB) ? ~nib_b : nib_b;
    nib_sum   = {1'b0, nib_a} + {1'b0, nib_b_eff} + {4'b0000, carry_r};
    nib_res   = 4'h0;
    nib_carry = carry_r;
    case (op_r)
      ALU_ADD, ALU_SUB: begin
        nib_res   = nib_sum[3:0];
        nib_carry = nib_sum[4];
      end
      ALU_AND: nib_res = nib_a & nib_b;
      ALU_OR:  nib_res = nib_a | nib_b;
      ALU_XOR: nib_res = nib_a ^ nib_b;
      default: nib_res = 4'h0;
    endcase
  end

  // Next-state logic: start latching in IDLE, one nibble per cycle in RUN
  always_comb begin
    state_nx  = state_r;
    idx_nx    = idx_r;
    result_nx = result_r;
    carry_nx  = carry_r;
    op_nx     = op_r;
    w1_nx     = w1_r;
    w2_nx     = w2_r;
    case (state_r)
      ST_IDLE: begin
        if (perm_to_count) begin
          state_nx  = ST_RUN;
          idx_nx    = 3'd0;
          result_nx = 32'h0000_0000;
          carry_nx  = (alu_ctrl == ALU_SUB);
          op_nx     = alu_ctrl;
          w1_nx     = word1;
          w2_nx     = word2;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_nx[{idx_r, 2'b00} +: 4] = nib_res;
        carry_nx = nib_carry;
        if (idx_r == 3'd7) begin
          // carry out of the top nibble is dropped: result is mod 2^32
          state_nx = ST_IDLE;
          idx_nx   = 3'd0;
        end else begin
          idx_nx = idx_r + 3'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  // ALU state registers with asynchronous abort on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= 3'd0;
      result_r <= 32'h0000_0000;
      carry_r  <= 1'b0;
      op_r     <= ALU_NONE;
      w1_r     <= 32'h0000_0000;
      w2_r     <= 32'h0000_0000;
    end else begin
      state_r  <= state_nx;
      idx_r    <= idx_nx;
      result_r <= result_nx;
      carry_r  <= carry_nx;
      op_r     <= op_nx;
      w1_r     <= w1_nx;
      w2_r     <= w2_nx;
    end
  end

  assign busy       = (state_r == ST_RUN);
  assign nibble_idx = idx_r;
  assign result     = result_r;

endmodule

// File: tb/tb_instr_decode_nibble_alu.sv
// Testbench for instr_decode_nibble_alu: decoder vectors plus a scoreboard
// for the nibble-serial ALU fed from a behavioural reference model.
module tb_instr_decode_nibble_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [2:0]  alu_ctrl = 3'd0;
  logic [31:0] word1 = 32'h0;
  logic [31:0] word2 = 32'h0;
  logic        perm_to_count = 1'b0;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [11:0] jump_addr;
  logic [2:0]  alu_cmd;
  logic [31:0] result;
  logic        busy;
  logic [2:0]  nibble_idx;

  instr_decode_nibble_alu dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_ctrl(alu_ctrl),
    .word1(word1), .word2(word2), .perm_to_count(perm_to_count),
    .opcode(opcode), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .jump_addr(jump_addr), .alu_cmd(alu_cmd),
    .result(result), .busy(busy), .nibble_idx(nibble_idx)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  bit          abort    = 1'b0;
  bit          busy_prev = 1'b0;
  int          run_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference ALU: whole-word arithmetic, results wrap at 32 bits
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  // Reference decoder check against the RV32I field rules
  task automatic dec_check(input logic [31:0] ins);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] e_imm;
    logic [11:0] e_j;
    logic [2:0]  e_cmd;
    logic [11:0] i12;
    instr = ins;
    #1;
    op = ins[6:0];
    f3 = ins[14:12];
    e_imm = 32'h0; e_j = 12'h0; e_cmd = 3'd5;
    if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) begin
      i12 = ins[31:20];
      e_imm = 32'($signed(i12));
    end else if (op == 7'b0100011) begin
      i12 = {ins[31:25], ins[11:7]};
      e_imm = 32'($signed(i12));
    end
    if (op == 7'b1100011) e_j = {ins[31], ins[7], ins[30:25], ins[11:8]};
    if (op == 7'b0000011 || op == 7'b0100011) e_cmd = 3'd0;
    if (op == 7'b0010011 || op == 7'b0110011) begin
      if (f3 == 3'b000) e_cmd = (op == 7'b0110011 && ins[30]) ? 3'd1 : 3'd0;
      else if (f3 == 3'b100) e_cmd = 3'd4;
      else if (f3 == 3'b110) e_cmd = 3'd3;
      else if (f3 == 3'b111) e_cmd = 3'd2;
    end
    check("dec_opcode", 32'(opcode), 32'(op));
    check("dec_funct3", 32'(funct3), 32'(f3));
    check("dec_rs1",    32'(rs1),    32'(ins[19:15]));
    check("dec_rs2",    32'(rs2),    32'(ins[24:20]));
    check("dec_rd",     32'(rd),     32'(ins[11:7]));
    check("dec_imm",    imm,         e_imm);
    check("dec_jump",   32'(jump_addr), 32'(e_j));
    check("dec_alucmd", 32'(alu_cmd), 32'(e_cmd));
  endtask

  // Issue one operation; called at a negedge with busy low. Operands and
  // perm_to_count are scrambled while busy to prove they are latched.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int cyc;
    alu_ctrl = op; word1 = a; word2 = b; perm_to_count = 1'b1;
    exp_q.push_back(alu_ref(op, a, b));
    @(posedge clk); #1;
    check("start_busy", 32'(busy), 32'd1);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (cyc > 20) begin
        check("busy_timeout", 32'(cyc), 32'd8);
        break;
      end
      alu_ctrl = 3'($urandom); word1 = $urandom; word2 = $urandom;
      perm_to_count = hold ? 1'b1 : 1'($urandom_range(0, 1));
    end
    perm_to_count = hold;
  endtask

  // Monitor: tracks nibble stepping and pops expectations when busy falls
  always @(negedge clk) begin
    if (busy) begin
      check("nibble_idx", 32'(nibble_idx), 32'(run_cnt));
      run_cnt++;
    end else if (busy_prev) begin
      if (abort) begin
        abort = 1'b0;
      end else begin
        check("busy_cycles", 32'(run_cnt), 32'd8);
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("result", result, exp_q.pop_front());
      end
      run_cnt = 0;
    end
    busy_prev = busy;
  end

  logic [6:0] opc_tab [8] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110011, 7'b1101111, 7'b0110111};

  initial begin
    logic [31:0] ins;
    int wait_cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_result", result,          32'd0);
    check("rst_idx",    32'(nibble_idx), 32'd0);
    rst_n = 1'b1;

    // Decoder: directed vectors
    instr = 32'h07B00293; #1;
    check("addi_opcode", 32'(opcode), 32'h13);
    check("addi_rd", 32'(rd), 32'd5);
    check("addi_rs1", 32'(rs1), 32'd0);
    check("addi_imm", imm, 32'd123);
    check("addi_cmd", 32'(alu_cmd), 32'd0);
    instr = 32'h0052A303; #1;
    check("lw_opcode", 32'(opcode), 32'h03);
    check("lw_rd", 32'(rd), 32'd6);
    check("lw_rs1", 32'(rs1), 32'd5);
    check("lw_funct3", 32'(funct3), 32'd2);
    check("lw_imm", imm, 32'd5);
    check("lw_cmd", 32'(alu_cmd), 32'd0);
    instr = 32'h002081B3; #1;
    check("add_rd", 32'(rd), 32'd3);
    check("add_rs1", 32'(rs1), 32'd1);
    check("add_rs2", 32'(rs2), 32'd2);
    check("add_cmd", 32'(alu_cmd), 32'd0);
    check("add_imm", imm, 32'd0);
    instr = 32'h402081B3; #1;
    check("sub_cmd", 32'(alu_cmd), 32'd1);
    instr = 32'hFFF00093; #1;
    check("addi_neg_imm", imm, 32'hFFFFFFFF);
    instr = 32'hFE20AC23; #1;
    check("sw_imm", imm, 32'hFFFFFFF8);
    check("sw_cmd", 32'(alu_cmd), 32'd0);
    instr = 32'hFE000EE3; #1;
    check("beq_jump", 32'(jump_addr), 32'hFFE);
    check("beq_imm", imm, 32'd0);
    check("beq_cmd", 32'(alu_cmd), 32'd5);

    // Decoder: randomized against the reference rules
    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      if (i % 4 != 3) ins[6:0] = opc_tab[$urandom_range(0, 7)];
      dec_check(ins);
    end

    // ALU: directed operations
    @(negedge clk);
    run_op(3'd0, 32'd0, 32'd123, 1'b0);
    run_op(3'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_op(3'd1, 32'd5, 32'd7, 1'b0);
    run_op(3'd2, 32'hF0F0AAAA, 32'h0FF05555, 1'b0);
    run_op(3'd3, 32'hF0F0AAAA, 32'h0FF05555, 1'b0);
    run_op(3'd4, 32'hF0F0AAAA, 32'h0FF05555, 1'b0);
    run_op(3'd6, 32'h12345678, 32'h9ABCDEF0, 1'b0);

    // Back-to-back with perm_to_count held high
    run_op(3'd0, 32'h0000FFFF, 32'h00000001, 1'b1);
    run_op(3'd1, 32'h00000000, 32'h00000001, 1'b1);
    run_op(3'd4, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);

    // Randomized operations
    for (int i = 0; i < 30; i++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    perm_to_count = 1'b0;

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    run_cnt = run_cnt;
    alu_ctrl = 3'd0; word1 = 32'h11111111; word2 = 32'h22222222; perm_to_count = 1'b1;
    exp_q.push_back(alu_ref(3'd0, 32'h11111111, 32'h22222222));
    @(posedge clk); #1;
    perm_to_count = 1'b0;
    wait_cyc = 0;
    while (1) begin
      @(negedge clk);
      wait_cyc++;
      if (nibble_idx == 3'd4 || wait_cyc > 12) break;
    end
    check("reach_nibble4", 32'(nibble_idx), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(busy),       32'd0);
    check("abort_result", result,          32'd0);
    check("abort_idx",    32'(nibble_idx), 32'd0);
    exp_q.delete();
    abort = 1'b1;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("no_restart", 32'(busy), 32'd0);

    // Recovery after reset
    run_op(3'd1, 32'h80000000, 32'h00000001, 1'b0);
    run_op(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    perm_to_count = 1'b0;

    repeat (12) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_decode_nibble_alu.md
Name: instr_decode_nibble_alu

Overview:
- RV32I instruction decoder (combinational) plus a nibble-serial 32-bit ALU (sequential, 4 bits per clock) in one block.
- Sits between the core control FSM and the register file / memory.
- The control FSM presents an instruction and operands, raises perm_to_count, and waits for busy to fall before taking result.

Parameters:
- None. Width is fixed at 32 bits, with 8 nibbles per operation.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word to decode.
- alu_ctrl  in  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; 5-7 NONE.
- word1  in  32  ALU operand 1.
- word2  in  32  ALU operand 2.
- perm_to_count  in  1  ALU start request (level-sensitive).
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- rd  out  5  instr[11:7].
- imm  out  32  sign-extended immediate.
- jump_addr  out  12  signed B-type offset, bits [12:1].
- alu_cmd  out  3  decoded ALU operation, same encoding as alu_ctrl.
- result  out  32  ALU result.
- busy  out  1  ALU operation in progress.
- nibble_idx  out  3  index of the nibble processed next.

Behaviour:
- Decoder is purely combinational, with no dependence on clk or rst_n.
- imm selection:
  - OP_IMM (0010011), LOAD (0000011), JALR (1100111): sign-extended instr[31:20].
  - STORE (0100011): sign-extended {instr[31:25], instr[11:7]}.
  - All other opcodes: 0.
- jump_addr: {instr[31], instr[7], instr[30:25], instr[11:8]} for BRANCH (1100011); 0 otherwise.
- alu_cmd for OP_IMM: funct3 000 ADD, 100 XOR, 110 OR, 111 AND; other funct3 NONE.
- alu_cmd for OP (0110011):
  - funct3 000: ADD if instr[30]=0, SUB if instr[30]=1.
  - funct3 100 XOR, 110 OR, 111 AND.
  - Other funct3: NONE.
- alu_cmd for LOAD/STORE: ADD (address calculation). All other opcodes: NONE.
- Reset (rst_n low, asynchronous): busy=0, nibble_idx=0, result=0, internal carry=0.
- ALU start: on a rising edge with busy=0 and perm_to_count=1:
  - latch alu_ctrl, word1, word2;
  - result<=0, nibble_idx<=0, busy<=1;
  - carry<=1 for SUB, 0 otherwise.
- While busy=1, one nibble per edge, processing nibble i=nibble_idx:
  - ADD: {c,r} = w1[i]+w2[i]+carry.
  - SUB: {c,r} = w1[i]+~w2[i]+carry (two's complement).
  - AND/OR/XOR: bitwise; carry unused.
  - NONE: r=0.
  - result[4i+3:4i]<=r, carry<=c, nibble_idx<=i+1.
  - When i=7: busy<=0, nibble_idx<=0.
- Latency: busy is high for exactly 8 cycles after the start edge; result is final on the edge where busy falls.
- result holds until the next start; carry out of nibble 7 is discarded (mod 2^32).
- perm_to_count and alu_ctrl/word1/word2 changes are ignored while busy=1, because operands are latched at start.
- perm_to_count still high when busy falls: a new operation starts on the next edge, giving a minimum one idle cycle between operations.
- rst_n asserted mid-operation aborts immediately to the reset values; no restart without a new start.

Test Plan:
- Decode: instr=0x07B00293 (addi x5,x0,123) -> opcode 0010011, rd=5, rs1=0, funct3=0, imm=123, alu_cmd=ADD. Decode: instr=0x0052A303 (lw x6,5(x5)) -> opcode 0000011, rd=6, rs1=5, funct3=010, imm=5, alu_cmd=ADD.
- Decode: instr=0x002081B3 (add x3,x1,x2) -> rd=3, rs1=1, rs2=2, alu_cmd=ADD, imm=0. Decode: 0x402081B3 (sub) -> alu_cmd=SUB. Decode: 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF.
- ALU ADD: word1=0, word2=123, one-cycle perm_to_count pulse -> busy high 8 cycles, nibble_idx steps 0..7, result=0x0000007B when busy falls. Carry propagation: 0xFFFFFFFF+1 -> result 0x00000000.
- ALU SUB: 5-7 -> 0xFFFFFFFE. Logic ops on 0xF0F0AAAA and 0x0FF05555: AND 0x00F00000, OR 0xFFF0FFFF, XOR 0xFF00FFFF.
- Operands changed and perm_to_count toggled mid-operation -> result reflects latched operands only. perm_to_count held high -> back-to-back operations separated by one idle cycle.
- rst_n pulsed low at nibble 4 -> busy=0, result=0, nibble_idx=0 immediately (asynchronous); the next start computes correctly.
